// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: scanout reads always win, queued writer transactions drain on free cycles.
// Optional build macro VGA_FB_VBLANK_WRITE_EN restricts write drain to vertical blanking.
module vga_fb_arbiter #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter int WQ_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clk_en,
  input  logic [10:0]               h_count,
  input  logic [10:0]               v_count,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      hblank_in,
  input  logic                      vblank_in,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic [DATA_W-1:0]         pix_data,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      blank_out,
  output logic [$clog2(WQ_DEPTH):0] wq_level,
  output logic                      addr_err,
  output logic                      frame_start
);

  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]  LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0]  LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(WQ_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   FB_SIZE  = (ADDR_W+1)'(FB_W * FB_H);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_SCAN_HOLD = 2'd2
  } drain_state_e;

  logic [ADDR_W-1:0] wq_addr_r [WQ_DEPTH];
  logic [DATA_W-1:0] wq_data_r [WQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [LVL_W-1:0]  level_nxt_s;

  logic              read_s;
  logic              push_s;
  logic              pop_s;
  logic              wr_window_s;
  logic              head_oor_s;
  logic [ADDR_W-1:0] scan_addr_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;

  drain_state_e      state_r;
  drain_state_e      prior_r;
  logic [DATA_W-1:0] hold_r;
  logic              rd_issued_r;
  logic              hsync_d_r;
  logic              vsync_d_r;
  logic              blank_d_r;
  logic              vblank_prev_r;
  logic              addr_err_r;
  logic              frame_start_r;

`ifdef VGA_FB_VBLANK_WRITE_EN
  // Tear-free update: the buffer only changes while the beam is in vertical blanking.
  assign wr_window_s = vblank_in;
`else
  assign wr_window_s = 1'b1;
`endif

  assign read_s      = clk_en & ~hblank_in & ~vblank_in;
  assign scan_addr_s = ADDR_W'((32'(v_count >> SCALE_SHIFT) * 32'(FB_W)) + 32'(h_count >> SCALE_SHIFT));
  assign head_addr_s = wq_addr_r[rd_ptr_r];
  assign head_data_s = wq_data_r[rd_ptr_r];
  assign head_oor_s  = ({1'b0, head_addr_s} >= FB_SIZE);

  // Ready looks only at the registered level, so a pop never opens the door in its own cycle.
  assign wr_ready    = (level_r < LVL_FULL);
  assign push_s      = wr_valid & wr_ready;
  assign pop_s       = (level_r != LVL_ZERO) & ~read_s & wr_window_s;

  assign wq_level    = level_r;
  assign addr_err    = addr_err_r;
  assign frame_start = frame_start_r;

  // Next queue occupancy from push/pop of this cycle.
  always_comb begin
    level_nxt_s = level_r;
    if (push_s && !pop_s) begin
      level_nxt_s = level_r + LVL_ONE;
    end else if (!push_s && pop_s) begin
      level_nxt_s = level_r - LVL_ONE;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // RAM port mux; strobes are held off while reset is asserted so no partial write escapes.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {ADDR_W{1'b0}};
    ram_wdata = {DATA_W{1'b0}};
    if (!reset_n) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end else if (read_s) begin
      ram_en   = 1'b1;
      ram_addr = scan_addr_s;
    end else if (pop_s) begin
      ram_en    = ~head_oor_s;
      ram_we    = ~head_oor_s;
      ram_addr  = head_addr_s;
      ram_wdata = head_data_s;
    end else begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  // Write-queue storage, no reset needed since pointers gate validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      wq_addr_r[wr_ptr_r] <= wr_addr;
      wq_data_r[wr_ptr_r] <= wr_data;
    end
  end

  // Write-queue pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= LVL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
    end
  end

  // Drain FSM; SCAN_HOLD marks the cycle after a read, when the RAM returns scanout data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      prior_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (read_s) begin
            state_r <= ST_SCAN_HOLD;
            prior_r <= ST_IDLE;
          end else if (level_r != LVL_ZERO) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (read_s) begin
            state_r <= ST_SCAN_HOLD;
            prior_r <= ST_DRAIN;
          end else if (level_nxt_s == LVL_ZERO) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_SCAN_HOLD: begin
          state_r <= prior_r;
        end
        default: begin
          state_r <= ST_IDLE;
          prior_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture scanout data one clk after the read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_r <= {DATA_W{1'b0}};
    end else if (state_r == ST_SCAN_HOLD) begin
      hold_r <= ram_rdata;
    end
  end

  // Pixel/timing pipeline: everything emerges exactly one clk_en period after sampling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_data    <= {DATA_W{1'b0}};
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
      blank_out   <= 1'b0;
      hsync_d_r   <= 1'b1;
      vsync_d_r   <= 1'b1;
      blank_d_r   <= 1'b0;
      rd_issued_r <= 1'b0;
    end else if (clk_en) begin
      pix_data    <= rd_issued_r ? hold_r : {DATA_W{1'b0}};
      hsync_out   <= hsync_d_r;
      vsync_out   <= vsync_d_r;
      blank_out   <= blank_d_r;
      hsync_d_r   <= hsync_in;
      vsync_d_r   <= vsync_in;
      blank_d_r   <= hblank_in | vblank_in;
      rd_issued_r <= read_s;
    end
  end

  // Sticky range error and vblank falling-edge pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_err_r    <= 1'b0;
      vblank_prev_r <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      if (pop_s && head_oor_s) begin
        addr_err_r <= 1'b1;
      end
      vblank_prev_r <= vblank_in;
      frame_start_r <= vblank_prev_r & ~vblank_in;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter with a behavioural single-port RAM.
module tb_vga_fb_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clk_en;
  logic [10:0]       h_count, v_count;
  logic              hsync_in, vsync_in, hblank_in, vblank_in;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              hsync_out, vsync_out, blank_out;
  logic [2:0]        wq_level;
  logic              addr_err, frame_start;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wlog_addr [$];
  logic [DATA_W-1:0] wlog_data [$];
  int reads = 0;
  int wr_on_en = 0;
  int collisions = 0;

  int stalls, max_lvl, sent;
  logic              last_en, last_we;
  logic [ADDR_W-1:0] last_addr;
  int n0, r0, e0, c0;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .h_count(h_count), .v_count(v_count),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .pix_data(pix_data),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
    .wq_level(wq_level), .addr_err(addr_err), .frame_start(frame_start)
  );

  // Single-port RAM with one-clk read latency, plus a log of every write beat.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        wlog_addr.push_back(ram_addr);
        wlog_data.push_back(ram_wdata);
        if (clk_en) wr_on_en <= wr_on_en + 1;
        if (clk_en && !hblank_in && !vblank_in) collisions <= collisions + 1;
      end else begin
        ram_rdata <= mem[ram_addr];
        reads <= reads + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_timing(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb);
    h_count = h; v_count = v; hblank_in = hb; vblank_in = vb;
  endtask

  // Writer offers n beats (addr base+i, data dbase+i) for a fixed number of clks, clk_en on even clks.
  task automatic burst(input int n, input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] dbase,
                       input int cycles);
    int idx;
    logic acc;
    idx = 0; stalls = 0; max_lvl = 0;
    for (int c = 0; c < cycles; c++) begin
      clk_en   = (c % 2 == 0);
      wr_valid = (idx < n);
      wr_addr  = base + ADDR_W'(idx);
      wr_data  = dbase + DATA_W'(idx);
      #1;
      if (wr_valid && !wr_ready) stalls++;
      if (int'(wq_level) > max_lvl) max_lvl = int'(wq_level);
      acc = wr_valid & wr_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    clk_en = 1'b0;
    wr_valid = 1'b0;
    sent = idx;
  endtask

  // One pixel: clk_en for one clk then two idle clks; records the strobes of the clk_en cycle.
  task automatic pixel(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb,
                       input logic hs, input logic vs);
    set_timing(h, v, hb, vb);
    hsync_in = hs; vsync_in = vs;
    clk_en = 1'b1;
    #1;
    last_en = ram_en; last_we = ram_we; last_addr = ram_addr;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    step(2);
  endtask

  initial begin
    reset_n = 1'b0; clk_en = 1'b0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0;
    set_timing(11'd0, 11'd0, 1'b0, 1'b0);
    hsync_in = 1'b1; vsync_in = 1'b1;
    step(3);
    check("rst_level", 32'(wq_level), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_pix", 32'(pix_data), 32'd0);
    check("rst_hsync", 32'(hsync_out), 32'd1);
    check("rst_vsync", 32'(vsync_out), 32'd1);
    check("rst_blank", 32'(blank_out), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    reset_n = 1'b1;
    step(2);

    // Preload two pixels through the writer path during hblank.
    set_timing(11'd640, 11'd4, 1'b1, 1'b0);
    n0 = wlog_addr.size();
    burst(1, 15'd162, 8'h5A, 2);
    burst(1, 15'd163, 8'h33, 2);
    check("preload_cnt", 32'(wlog_addr.size() - n0), 32'd2);

    // Scanout read at (8,4) -> buffer (2,1) -> 162; pixel appears one clk_en later.
    pixel(11'd8, 11'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rd_en", 32'(last_en), 32'd1);
    check("rd_we", 32'(last_we), 32'd0);
    check("rd_addr", 32'(last_addr), 32'd162);
    pixel(11'd12, 11'd4, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rd_addr2", 32'(last_addr), 32'd163);
    check("pix_5a", 32'(pix_data), 32'h5A);
    check("pix_blank0", 32'(blank_out), 32'd0);
    check("hsync_delay", 32'(hsync_out), 32'd0);
    check("vsync_delay", 32'(vsync_out), 32'd1);

    // Entering hblank: no read, blank and zero pixel follow one clk_en later.
    pixel(11'd640, 11'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    check("hb_no_read", 32'(last_en), 32'd0);
    check("pix_33", 32'(pix_data), 32'h33);
    check("hb_blank_lag", 32'(blank_out), 32'd0);
    pixel(11'd644, 11'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    check("hb_pix0", 32'(pix_data), 32'd0);
    check("hb_blank1", 32'(blank_out), 32'd1);

    // hblank drain: writes go out on every clk, including clk_en clks.
    n0 = wlog_addr.size(); r0 = reads; e0 = wr_on_en;
    burst(3, 15'd500, 8'h50, 6);
    check("hb_wr_cnt", 32'(wlog_addr.size() - n0), 32'd3);
    check("hb_wr_on_en", 32'(wr_on_en - e0), 32'd1);
    check("hb_reads", 32'(reads - r0), 32'd0);
    for (int i = 0; i < 3; i++) check("hb_wr_addr", 32'(wlog_addr[n0+i]), 32'(500 + i));

    // Active video, clk_en every other clk, writer pushes 10 beats back to back.
    set_timing(11'd8, 11'd4, 1'b0, 1'b0);
    n0 = wlog_addr.size(); r0 = reads; c0 = collisions;
    burst(10, 15'd200, 8'hA0, 40);
    check("w_sent", 32'(sent), 32'd10);
    check("w_stalls", 32'(stalls), 32'd3);
    check("w_max_lvl", 32'(max_lvl), 32'd4);
    check("w_cnt", 32'(wlog_addr.size() - n0), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check("w_addr", 32'(wlog_addr[n0+i]), 32'(200 + i));
      check("w_data", 32'(wlog_data[n0+i]), 32'(8'hA0 + i));
    end
    check("w_collide", 32'(collisions - c0), 32'd0);
    check("w_reads", 32'(reads - r0), 32'd20);
    check("w_level_end", 32'(wq_level), 32'd0);

    // Reset mid-frame with three entries queued.
    n0 = wlog_addr.size();
    burst(5, 15'd400, 8'h10, 5);
    check("mid_level3", 32'(wq_level), 32'd3);
    check("mid_written", 32'(wlog_addr.size() - n0), 32'd2);
    wr_valid = 1'b1; wr_addr = 15'd450; wr_data = 8'hEE;
    reset_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(wq_level), 32'd0);
    check("mid_rst_ready", 32'(wr_ready), 32'd1);
    check("mid_rst_ram_en", 32'(ram_en), 32'd0);
    check("mid_rst_pix", 32'(pix_data), 32'd0);
    step(2);
    wr_valid = 1'b0;
    reset_n = 1'b1;
    step(3);
    check("mid_discard", 32'(wlog_addr.size() - n0), 32'd2);

    // Range boundary: last valid address writes, first invalid one flags a sticky error.
    set_timing(11'd640, 11'd4, 1'b1, 1'b0);
    n0 = wlog_addr.size();
    burst(1, 15'd19199, 8'h77, 4);
    check("oor_last_ok", 32'(wlog_addr.size() - n0), 32'd1);
    check("oor_last_addr", 32'(wlog_addr[n0]), 32'd19199);
    check("oor_err0", 32'(addr_err), 32'd0);
    n0 = wlog_addr.size();
    burst(1, 15'd19200, 8'h78, 4);
    check("oor_no_write", 32'(wlog_addr.size() - n0), 32'd0);
    check("oor_err1", 32'(addr_err), 32'd1);
    check("oor_level", 32'(wq_level), 32'd0);
    n0 = wlog_addr.size();
    burst(1, 15'd700, 8'h79, 4);
    check("oor_next_ok", 32'(wlog_addr.size() - n0), 32'd1);
    check("oor_sticky", 32'(addr_err), 32'd1);

    // Falling edge of vblank gives a one-clk pulse.
    vblank_in = 1'b1;
    step(1);
    vblank_in = 1'b0;
    step(1);
    check("frame_start_hi", 32'(frame_start), 32'd1);
    step(1);
    check("frame_start_lo", 32'(frame_start), 32'd0);

    // Write issued at line 100.
    set_timing(11'd640, 11'd100, 1'b1, 1'b0);
    n0 = wlog_addr.size();
`ifdef VGA_FB_VBLANK_WRITE_EN
    burst(1, 15'd600, 8'h66, 6);
    check("vbw_held", 32'(wlog_addr.size() - n0), 32'd0);
    check("vbw_level", 32'(wq_level), 32'd1);
    vblank_in = 1'b1;
    step(1);
    check("vbw_popped", 32'(wlog_addr.size() - n0), 32'd1);
    check("vbw_level0", 32'(wq_level), 32'd0);
`else
    burst(1, 15'd600, 8'h66, 2);
    check("v100_popped", 32'(wlog_addr.size() - n0), 32'd1);
    check("v100_data", 32'(wlog_data[n0]), 32'h66);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
